ttt_auto_player: RTL and testbench
==================================

// Module: ttt_auto_player
// PURPOSE
//  Automatic player that drives the tic_tac_toe game interface (cell_select/place) for one side.
//  Keeps a shadow board from its own acknowledged moves and the observed opponent moves.
//  On its turn it picks a free cell, issues a one-cycle place pulse, then waits for the turn to change.
//  Sits next to tic_tac_toe as the move source for X or O; the other side is a human or a second instance.
// PARAMETERS
//  ACK_TIMEOUT  16  cycles in WAIT_ACK without an ack before err_timeout is raised (>=2)
//  TMR_W        5   ack timer width; must hold ACK_TIMEOUT
// PORTS
//  clk             in   1  rising-edge clock
//  reset           in   1  asynchronous, active-high reset
//  enable          in   1  1 = allowed to play; sampled only in IDLE
//  my_side         in   1  side played: 0 = X, 1 = O; hold stable while out of reset
//  current_player  in   1  game's turn indicator (0 = X, 1 = O)
//  game_over       in   1  game finished
//  opp_cell        in   4  opponent's cell index 0..8, row-major
//  opp_place       in   1  opponent place strobe, 1 cycle
//  cell_select     out  4  cell driven to the game
//  place           out  1  place strobe to the game
//  busy            out  1  1 in SCAN, ISSUE and WAIT_ACK
//  done            out  1  sticky; game ended or no free cell
//  no_move         out  1  sticky; board full on our turn
//  err_timeout     out  1  sticky; ack not seen within ACK_TIMEOUT
//  moves_made      out  4  count of acknowledged own moves, 0..5
// BEHAVIOUR
//  Reset (async): all outputs 0, own_mask and opp_mask 9'b0, state IDLE, idx 0, timer 0.
//  Shadow board:
//  - occupied = own_mask | opp_mask.
//  - opp_place records opp_cell into opp_mask only if current_player != my_side, opp_cell <= 8 and the cell is free.
//  - Any other opp_place is ignored, including one that arrives during our turn.
//  FSM (registered outputs):
//  - IDLE: if game_over -> DONE. Else if enable && current_player == my_side -> SCAN with idx = 0.
//  - SCAN: tests one cell per cycle at idx.
//    - If free: cell_select <= idx, -> ISSUE.
//    - Else if idx == 8: no_move <= 1 -> DONE.
//    - Else idx++.
//    - game_over in SCAN -> DONE; no place is issued.
//  - ISSUE: place = 1 for exactly this one cycle, -> WAIT_ACK with timer = 0. cell_select stays held until the next ISSUE.
//  - WAIT_ACK: ack = (current_player != my_side) || game_over.
//    - On ack: set the cell in own_mask, moves_made++, then -> DONE if game_over, else -> IDLE.
//    - No ack: timer++. When timer == ACK_TIMEOUT-1: err_timeout <= 1 -> ERROR.
//  - DONE: done = 1; held until reset.
//  - ERROR: held until reset; place never reasserted.
//  Latency: turn seen in IDLE at cycle n -> place high at cycle n+2+k, where k = index of the first free cell.
//  Mid-game reset: masks and counters cleared. A place pulse in flight is dropped immediately (async).
//  enable is checked only in IDLE; deasserting it later does not abort a move already in progress.
// CONFIGURATION
//  TTT_WIN_SEEK_EN defined:
//  - In IDLE on our turn, a combinational check covers all 8 lines (3 rows, 3 columns, 2 diagonals).
//  - A line with two own_mask cells and one free cell selects that free cell (lowest index on ties).
//  - Path is IDLE -> ISSUE directly, so place is high at n+1.
//  - If no such line exists, the normal SCAN path is used.
//  TTT_WIN_SEEK_EN undefined: the win check is not synthesised; always first-free scan.
// TESTING
//  1) reset, my_side=0, enable=1, current_player=0 at n -> place=1 only at n+2, cell_select=0;
//     current_player->1 -> moves_made=1, IDLE.
//  2) opp moves 0,1 recorded; our turn at n -> place at n+4, cell_select=2.
//  3) hold current_player == my_side after place -> err_timeout=1 after 16 cycles; no second place.
//  4) masks covering all 9 cells, our turn -> no_move=1, done=1, place stays 0.
//  5) game_over=1 (current_player unchanged) during WAIT_ACK -> moves_made++, done=1.
//  6) WIN_SEEK_EN: own {0,1}, opp {3,4}, turn at n -> place at n+1, cell_select=2;
//     without the macro -> place at n+4, cell_select=2.

Source files
------------

// File: rtl/ttt_auto_player.sv
// ttt_auto_player: automatic move source for one side of the tic_tac_toe game.
// Keeps a shadow board (own acknowledged moves + observed opponent moves), picks
// a free cell on its turn, pulses place for one cycle and waits for the turn to flip.
// Optional build macro TTT_WIN_SEEK_EN: on our turn, complete a line holding two own
// cells and one free cell straight from IDLE instead of scanning for the first free cell.
// Handshake: place is a single-cycle strobe with cell_select stable; the game's
// acknowledgement is the turn leaving our side (or game_over) while in WAIT_ACK.
module ttt_auto_player #(
    parameter int ACK_TIMEOUT = 16,
    parameter int TMR_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       my_side,
    input  logic       current_player,
    input  logic       game_over,
    input  logic [3:0] opp_cell,
    input  logic       opp_place,
    output logic [3:0] cell_select,
    output logic       place,
    output logic       busy,
    output logic       done,
    output logic       no_move,
    output logic       err_timeout,
    output logic [3:0] moves_made,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } state_t;

    state_t           state;
    logic [8:0]       own_mask;
    logic [8:0]       opp_mask;
    logic [8:0]       occupied;
    logic [8:0]       opp_bit;
    logic [3:0]       idx;
    logic [TMR_W-1:0] timer;
    logic             turn;
    logic             ack;
    logic             opp_valid;

    assign occupied  = own_mask | opp_mask;
    assign turn      = (current_player == my_side);
    assign ack       = !turn || game_over;
    assign opp_bit   = 9'b1 << opp_cell;
    // Opponent moves only count while it is their turn and the cell is legal and empty.
    assign opp_valid = opp_place && !turn && (opp_cell <= 4'd8) && ((occupied & opp_bit) == 9'b0);
    assign state_dbg = state;

`ifdef TTT_WIN_SEEK_EN
    // Line masks: three rows, three columns, two diagonals (bit i = cell i, row-major).
    localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                         9'h092, 9'h124, 9'h111, 9'h054};
    logic [8:0] win_mask;
    logic       win_hit;
    logic [3:0] win_cell;

    // Collect the free cell of every line we could complete, then take the lowest index.
    always_comb begin
        win_mask = '0;
        for (int l = 0; l < 8; l++) begin
            if ($countones(own_mask & LINES[l]) == 2 && $countones(~occupied & LINES[l]) == 1)
                win_mask = win_mask | (~occupied & LINES[l]);
        end
        win_hit  = |win_mask;
        win_cell = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (win_mask[i]) win_cell = 4'(i);
        end
    end
`endif

    // Record accepted opponent moves into the shadow board.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opp_mask <= 9'b0;
        end else if (opp_valid) begin
            opp_mask <= opp_mask | opp_bit;
        end
    end

    // Move FSM with registered outputs; also owns own_mask and the move counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 4'd0;
            timer       <= '0;
            own_mask    <= 9'b0;
            cell_select <= 4'd0;
            place       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            no_move     <= 1'b0;
            err_timeout <= 1'b0;
            moves_made  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    place <= 1'b0;
                    if (game_over) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (enable && turn) begin
                        busy <= 1'b1;
`ifdef TTT_WIN_SEEK_EN
                        if (win_hit) begin
                            cell_select <= win_cell;
                            place       <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            idx   <= 4'd0;
                            state <= SCAN;
                        end
`else
                        idx   <= 4'd0;
                        state <= SCAN;
`endif
                    end
                end
                SCAN: begin
                    if (game_over) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (!occupied[idx]) begin
                        cell_select <= idx;
                        place       <= 1'b1;
                        state       <= ISSUE;
                    end else if (idx == 4'd8) begin
                        no_move <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ISSUE: begin
                    place <= 1'b0;
                    timer <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack) begin
                        own_mask   <= own_mask | (9'b1 << cell_select);
                        moves_made <= moves_made + 4'd1;
                        busy       <= 1'b0;
                        if (game_over) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ERROR;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DONE: begin
                    place <= 1'b0;
                    done  <= 1'b1;
                end
                ERROR: begin
                    place <= 1'b0;
                end
                default: begin
                    place <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_auto_player.sv
// tb_ttt_auto_player: directed bench for ttt_auto_player with a turn-level
// reference model checked every cycle, plus literal latency/cell expectations.
module tb_ttt_auto_player;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       my_side = 1'b0;
  logic       current_player = 1'b1;
  logic       game_over = 1'b0;
  logic [3:0] opp_cell = 4'd0;
  logic       opp_place = 1'b0;
  logic [3:0] cell_select;
  logic       place;
  logic       busy;
  logic       done;
  logic       no_move;
  logic       err_timeout;
  logic [3:0] moves_made;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int place_cnt = 0;
  int last_place_cyc = 0;
  int last_place_cell = 0;
  int c0;
  int p0;

  ttt_auto_player #(.ACK_TIMEOUT(16), .TMR_W(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .my_side(my_side),
    .current_player(current_player), .game_over(game_over),
    .opp_cell(opp_cell), .opp_place(opp_place),
    .cell_select(cell_select), .place(place), .busy(busy), .done(done),
    .no_move(no_move), .err_timeout(err_timeout), .moves_made(moves_made),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (turn level) ----------------
  localparam int M_IDLE = 0, M_SCAN = 1, M_PLACE = 2, M_WAIT = 3, M_STOP = 4;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  bit m_own [9];
  bit m_opp [9];
  int m_mode = M_IDLE;
  int m_cnt = 0;
  int m_target = 0;
  int m_t = 0;
  bit m_place = 0, m_busy = 0, m_done = 0, m_no_move = 0, m_err = 0;
  int m_cell = 0;
  int m_moves = 0;
  int mk, mw, moc;

  function automatic int model_first_free();
    for (int c = 0; c < 9; c++) if (!m_own[c] && !m_opp[c]) return c;
    return -1;
  endfunction

  function automatic int model_win();
    int best = -1;
    for (int l = 0; l < 8; l++) begin
      int own_n = 0;
      int free_n = 0;
      int free_c = -1;
      for (int j = 0; j < 3; j++) begin
        if (m_own[lines[l][j]]) own_n++;
        else if (!m_opp[lines[l][j]]) begin free_n++; free_c = lines[l][j]; end
      end
      if (own_n == 2 && free_n == 1 && (best < 0 || free_c < best)) best = free_c;
    end
    return best;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 9; c++) begin m_own[c] <= 0; m_opp[c] <= 0; end
      m_mode <= M_IDLE; m_cnt <= 0; m_target <= 0; m_t <= 0;
      m_place <= 0; m_busy <= 0; m_done <= 0; m_no_move <= 0; m_err <= 0;
      m_cell <= 0; m_moves <= 0;
    end else begin
      moc = int'(opp_cell);
      if (opp_place && current_player != my_side && moc <= 8) begin
        if (!m_own[moc] && !m_opp[moc]) m_opp[moc] <= 1;
      end
      case (m_mode)
        M_IDLE: begin
          if (game_over) begin
            m_done <= 1; m_mode <= M_STOP;
          end else if (enable && current_player == my_side) begin
            m_busy <= 1;
            mw = -1;
`ifdef TTT_WIN_SEEK_EN
            mw = model_win();
`endif
            if (mw >= 0) begin
              m_place <= 1; m_cell <= mw; m_mode <= M_PLACE;
            end else begin
              mk = model_first_free();
              m_target <= mk;
              m_cnt <= (mk < 0) ? 9 : mk + 1;
              m_mode <= M_SCAN;
            end
          end
        end
        M_SCAN: begin
          if (game_over) begin
            m_done <= 1; m_busy <= 0; m_mode <= M_STOP;
          end else if (m_cnt == 1) begin
            if (m_target < 0) begin
              m_no_move <= 1; m_done <= 1; m_busy <= 0; m_mode <= M_STOP;
            end else begin
              m_place <= 1; m_cell <= m_target; m_mode <= M_PLACE;
            end
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        M_PLACE: begin
          m_place <= 0; m_t <= 0; m_mode <= M_WAIT;
        end
        M_WAIT: begin
          if (current_player != my_side || game_over) begin
            m_own[m_cell] <= 1; m_moves <= m_moves + 1; m_busy <= 0;
            if (game_over) begin m_done <= 1; m_mode <= M_STOP; end
            else m_mode <= M_IDLE;
          end else if (m_t + 1 == 16) begin
            m_err <= 1; m_busy <= 0; m_mode <= M_STOP;
          end else begin
            m_t <= m_t + 1;
          end
        end
        default: m_place <= 0;
      endcase
    end
  end

  // scoreboard: every cycle out of reset, DUT outputs against the model
  always @(negedge clk) begin
    if (!reset) begin
      tests++;
      if (place !== m_place || cell_select !== 4'(m_cell) || busy !== m_busy ||
          done !== m_done || no_move !== m_no_move || err_timeout !== m_err ||
          moves_made !== 4'(m_moves)) begin
        fails++;
        $display("FAIL model_cycle %0d: dut place=%0b cell=%0d busy=%0b done=%0b no_move=%0b err=%0b moves=%0d; expected place=%0b cell=%0d busy=%0b done=%0b no_move=%0b err=%0b moves=%0d",
                 cyc, place, cell_select, busy, done, no_move, err_timeout, moves_made,
                 m_place, m_cell, m_busy, m_done, m_no_move, m_err, m_moves);
      end
      if (place) begin
        place_cnt++;
        last_place_cyc = cyc;
        last_place_cell = int'(cell_select);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic side, input logic cp);
    enable = 0; game_over = 0; opp_place = 0; opp_cell = 0;
    my_side = side; current_player = cp;
    reset = 1;
    #1;
    tick();
    reset = 0;
    tick();
  endtask

  task automatic opp_move(input int c);
    opp_cell = 4'(c);
    opp_place = 1;
    tick();
    opp_place = 0;
    tick();
  endtask

  task automatic start_turn(input logic side);
    current_player = side;
    c0 = cyc;
    p0 = place_cnt;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    #2;
    reset = 1;
    repeat (2) tick();
    check("rst_place", place, 0);
    check("rst_cell", cell_select, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_no_move", no_move, 0);
    check("rst_err", err_timeout, 0);
    check("rst_moves", moves_made, 0);
    check("rst_state", state_dbg, 0);
    reset = 0;
    tick();

    // 1) first move as X goes to cell 0, place two cycles after the turn is seen
    do_reset(1'b0, 1'b1);
    enable = 1;
    start_turn(1'b0);
    repeat (6) tick();
    check("t1_place_count", place_cnt - p0, 1);
    check("t1_latency", last_place_cyc - c0, 2);
    check("t1_cell", last_place_cell, 0);
    current_player = 1;
    tick();
    check("t1_moves", moves_made, 1);
    check("t1_state_idle", state_dbg, 0);
    check("t1_busy", busy, 0);

    // 2) opponent holds 0,1 (plus an illegal and a duplicate strobe): we take 2 at n+4
    do_reset(1'b0, 1'b1);
    enable = 1;
    opp_move(0);
    opp_move(1);
    opp_move(9);
    opp_move(0);
    start_turn(1'b0);
    repeat (8) tick();
    check("t2_place_count", place_cnt - p0, 1);
    check("t2_latency", last_place_cyc - c0, 4);
    check("t2_cell", last_place_cell, 2);
    current_player = 1;
    tick();
    check("t2_moves", moves_made, 1);

    // 3) no ack: timeout, error state, exactly one place
    do_reset(1'b0, 1'b1);
    enable = 1;
    start_turn(1'b0);
    repeat (24) tick();
    check("t3_err", err_timeout, 1);
    check("t3_state_error", state_dbg, 5);
    check("t3_busy", busy, 0);
    enable = 0;
    current_player = 1;
    repeat (3) tick();
    check("t3_single_place", place_cnt - p0, 1);
    check("t3_moves", moves_made, 0);

    // 4) full board on our turn: no_move and done, nothing placed
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) opp_move(i);
    enable = 1;
    start_turn(1'b0);
    repeat (14) tick();
    check("t4_no_move", no_move, 1);
    check("t4_done", done, 1);
    check("t4_no_place", place_cnt - p0, 0);
    check("t4_moves", moves_made, 0);

    // 5) O side; opponent strobe during our turn is ignored; game_over acks the move
    do_reset(1'b1, 1'b1);
    opp_move(0);
    enable = 1;
    start_turn(1'b1);
    repeat (4) tick();
    check("t5_latency", last_place_cyc - c0, 2);
    check("t5_cell_ignored_opp", last_place_cell, 0);
    game_over = 1;
    tick();
    check("t5_moves", moves_made, 1);
    check("t5_done", done, 1);
    game_over = 0;
    repeat (2) tick();
    check("t5_done_sticky", done, 1);

    // 6) own {0,1}, opp {3,4}: cell 2 either by win seek or by scan
    do_reset(1'b0, 1'b1);
    enable = 1;
    current_player = 0;
    repeat (4) tick();
    current_player = 1;
    tick();
    opp_move(3);
    current_player = 0;
    repeat (6) tick();
    check("t6_second_cell", last_place_cell, 1);
    current_player = 1;
    tick();
    opp_move(4);
    start_turn(1'b0);
    repeat (8) tick();
`ifdef TTT_WIN_SEEK_EN
    check("t6_latency", last_place_cyc - c0, 1);
`else
    check("t6_latency", last_place_cyc - c0, 4);
`endif
    check("t6_cell", last_place_cell, 2);
    current_player = 1;
    tick();
    check("t6_moves", moves_made, 3);

    // 7) dropping enable after the move starts does not abort it
    do_reset(1'b0, 1'b1);
    enable = 1;
    start_turn(1'b0);
    tick();
    enable = 0;
    repeat (5) tick();
    check("t7_place_count", place_cnt - p0, 1);
    check("t7_cell", last_place_cell, 0);

    // 8) async reset while place is high drops it at once
    do_reset(1'b0, 1'b1);
    enable = 1;
    start_turn(1'b0);
    repeat (2) tick();
    check("t8_place_before", place, 1);
    reset = 1;
    #1;
    check("t8_place_dropped", place, 0);
    check("t8_busy_dropped", busy, 0);
    tick();
    reset = 0;
    enable = 0;
    current_player = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
